// File: rtl/flags_ctx_pkg.sv
// Shared definitions for the flags context unit: flag bit positions, branch
// condition codes, FSM encoding and small evaluation/parity helpers.
package flags_ctx_pkg;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_S = 2;
    localparam int FLAG_O = 3;

    localparam logic [3:0] CC_AL = 4'd0;
    localparam logic [3:0] CC_EQ = 4'd1;
    localparam logic [3:0] CC_NE = 4'd2;
    localparam logic [3:0] CC_AE = 4'd3;
    localparam logic [3:0] CC_B  = 4'd4;
    localparam logic [3:0] CC_MI = 4'd5;
    localparam logic [3:0] CC_PL = 4'd6;
    localparam logic [3:0] CC_VS = 4'd7;
    localparam logic [3:0] CC_VC = 4'd8;
    localparam logic [3:0] CC_GT = 4'd9;
    localparam logic [3:0] CC_GE = 4'd10;
    localparam logic [3:0] CC_LT = 4'd11;
    localparam logic [3:0] CC_LE = 4'd12;
    localparam logic [3:0] CC_A  = 4'd13;
    localparam logic [3:0] CC_BE = 4'd14;
    localparam logic [3:0] CC_NV = 4'd15;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RESTORE = 1'b1
    } state_e;

    function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] f);
        logic res;
        res = 1'b0;
        case (cc)
            CC_AL:   res = 1'b1;
            CC_EQ:   res = f[FLAG_Z];
            CC_NE:   res = !f[FLAG_Z];
            CC_AE:   res = f[FLAG_C];
            CC_B:    res = !f[FLAG_C];
            CC_MI:   res = f[FLAG_S];
            CC_PL:   res = !f[FLAG_S];
            CC_VS:   res = f[FLAG_O];
            CC_VC:   res = !f[FLAG_O];
            CC_GT:   res = !f[FLAG_Z] && (f[FLAG_S] == f[FLAG_O]);
            CC_GE:   res = (f[FLAG_S] == f[FLAG_O]);
            CC_LT:   res = (f[FLAG_S] != f[FLAG_O]);
            CC_LE:   res = f[FLAG_Z] || (f[FLAG_S] != f[FLAG_O]);
            CC_A:    res = f[FLAG_C] && !f[FLAG_Z];
            CC_BE:   res = !f[FLAG_C] || f[FLAG_Z];
            CC_NV:   res = 1'b0;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic even_par(input logic [3:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/flags_ctx_unit_lifo.sv
// Register stack holding saved flag contexts; the top entry is always visible
// on dout so a pop can consume it in the same cycle the pointer moves.
module flags_lifo
    import flags_ctx_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic [CW-1:0]           count_q, count_d;
    logic [AW-1:0]           wr_idx_s, top_idx_s;

    assign wr_idx_s  = count_q[AW-1:0];
    assign top_idx_s = AW'(count_q - CW'(1));
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == {CW{1'b0}});
    assign count     = count_q;

    // Top-of-stack read; an empty stack presents zero.
    always_comb begin
        dout = {W{1'b0}};
        if (empty) begin
            dout = {W{1'b0}};
        end else begin
            dout = mem_q[top_idx_s];
        end
    end

    // Push/pop bookkeeping; a full push or empty pop leaves everything untouched.
    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (push && !full) begin
            mem_d[wr_idx_s] = din;
            count_d         = count_q + CW'(1);
        end else if (pop && !empty) begin
            count_d = count_q - CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Stack storage and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= '0;
            count_q <= {CW{1'b0}};
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/flags_ctx_unit.sv
// Branch condition evaluation plus trap flag save/restore for the ALU.
// Optional per-entry parity protection is enabled with FLAGS_CTX_PARITY_EN.
module flags_ctx_unit
    import flags_ctx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [3:0]               flags,
    input  logic                     bubble,
    input  logic                     br_valid,
    input  logic [3:0]               br_cond,
    input  logic                     trap_enter,
    input  logic                     trap_return,
    output logic                     br_taken,
    output logic                     br_taken_vld,
    output logic [31:0]              flags_restore,
    output logic                     flags_we,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     ovf_err,
    output logic                     unf_err
`ifdef FLAGS_CTX_PARITY_EN
    ,
    output logic                     par_err
`endif
);

`ifdef FLAGS_CTX_PARITY_EN
    localparam int LW = 5;
`else
    localparam int LW = 4;
`endif

    state_e        state_q, state_d;
    logic          br_taken_q, br_taken_d;
    logic          br_vld_q, br_vld_d;
    logic [3:0]    restore_q, restore_d;
    logic          we_q, we_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          push_s, pop_s;
    logic          lifo_full_s, lifo_empty_s;
    logic [LW-1:0] lifo_din_s, lifo_dout_s;
`ifdef FLAGS_CTX_PARITY_EN
    logic          par_q, par_d;
    assign lifo_din_s = {even_par(flags), flags};
    assign par_err    = par_q;
`else
    assign lifo_din_s = flags;
`endif

    flags_lifo #(
        .DEPTH (DEPTH),
        .W     (LW)
    ) u_lifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .din   (lifo_din_s),
        .dout  (lifo_dout_s),
        .full  (lifo_full_s),
        .empty (lifo_empty_s),
        .count (depth)
    );

    // Branch evaluation, trap FSM and sticky error next-state logic.
    always_comb begin
        state_d    = state_q;
        br_taken_d = br_taken_q;
        br_vld_d   = 1'b0;
        restore_d  = restore_q;
        we_d       = we_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        push_s     = 1'b0;
        pop_s      = 1'b0;
`ifdef FLAGS_CTX_PARITY_EN
        par_d      = par_q;
`endif
        if (br_valid) begin
            br_vld_d   = 1'b1;
            br_taken_d = cond_eval(br_cond, flags);
        end else begin
            br_vld_d   = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                // Enter takes priority; a coincident return is silently dropped.
                if (trap_enter) begin
                    if (lifo_full_s) begin
                        ovf_d = 1'b1;
                    end else begin
                        push_s = 1'b1;
                    end
                end else if (trap_return) begin
                    if (lifo_empty_s) begin
                        unf_d = 1'b1;
                    end else begin
                        pop_s   = 1'b1;
                        we_d    = 1'b1;
                        state_d = ST_RESTORE;
`ifdef FLAGS_CTX_PARITY_EN
                        if (lifo_dout_s[4] != even_par(lifo_dout_s[3:0])) begin
                            restore_d = 4'b0000;
                            par_d     = 1'b1;
                        end else begin
                            restore_d = lifo_dout_s[3:0];
                        end
`else
                        restore_d = lifo_dout_s;
`endif
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RESTORE: begin
                if (trap_enter) begin
                    ovf_d = 1'b1;
                end else begin
                    ovf_d = ovf_q;
                end
                if (trap_return) begin
                    unf_d = 1'b1;
                end else begin
                    unf_d = unf_q;
                end
                // Hold the restore request until the ALU actually captures flags.
                if (!bubble) begin
                    we_d    = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    we_d    = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                we_d    = 1'b0;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            br_taken_q <= 1'b0;
            br_vld_q   <= 1'b0;
            restore_q  <= 4'b0000;
            we_q       <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
`ifdef FLAGS_CTX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            br_taken_q <= br_taken_d;
            br_vld_q   <= br_vld_d;
            restore_q  <= restore_d;
            we_q       <= we_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
`ifdef FLAGS_CTX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign br_taken      = br_taken_q;
    assign br_taken_vld  = br_vld_q;
    assign flags_restore = {28'b0, restore_q};
    assign flags_we      = we_q;
    assign ovf_err       = ovf_q;
    assign unf_err       = unf_q;

endmodule
